// File: rtl/sxr_switch_conditioner_if.sv
//------------------------------------------------------------------------------
// Module   : sxr_switch_conditioner_if
// Brief    : Switch bus between the pins and the conditioner (raw in; stable
//            word, change strobe and per-bit edge pulses out).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sxr_switch_conditioner_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] i_sw_raw;
    logic [WIDTH-1:0] o_sw_stable;
    logic             o_sw_changed;
    logic [WIDTH-1:0] o_sw_rise;
    logic [WIDTH-1:0] o_sw_fall;

    modport master (
        output i_sw_raw,
        input  o_sw_stable,
        input  o_sw_changed,
        input  o_sw_rise,
        input  o_sw_fall
    );

    modport slave (
        input  i_sw_raw,
        output o_sw_stable,
        output o_sw_changed,
        output o_sw_rise,
        output o_sw_fall
    );
endinterface

`default_nettype wire

// File: rtl/sxr_switch_conditioner.sv
//------------------------------------------------------------------------------
// Module   : sxr_switch_conditioner
// Brief    : 2-FF synchroniser plus per-bit debounce for the core SW_in bus,
//            with a one-cycle change strobe. Define SW_EDGE_DETECT_EN to build
//            the per-bit rise/fall pulse registers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sxr_switch_conditioner #(
    parameter int WIDTH     = 5,
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3
) (
    input  wire                    clk,
    input  wire                    rst,
    sxr_switch_conditioner_if.slave sw
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0]            r_sync1;
    logic [WIDTH-1:0]            r_sync2;
    logic [WIDTH-1:0]            r_stable;
    logic                        r_changed;
    logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]            w_mismatch;
    logic [WIDTH-1:0]            w_update;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw.i_sw_raw;
            r_sync2 <= r_sync1;
        end
    end

    // A bit is accepted on the edge that would otherwise count its DB_CYCLES-th mismatch.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_mismatch[i] = (r_sync2[i] != r_stable[i]);
        assign w_update[i]   = w_mismatch[i] && (r_cnt[i] == C_CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!w_mismatch[i] || w_update[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable  <= '0;
            r_changed <= 1'b0;
        end else begin
            r_stable  <= (r_stable & ~w_update) | (r_sync2 & w_update);
            r_changed <= |w_update;
        end
    end

    assign sw.o_sw_stable  = r_stable;
    assign sw.o_sw_changed = r_changed;

`ifdef SW_EDGE_DETECT_EN
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    // The accepted value is r_sync2, so its polarity gives the edge direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_update & r_sync2;
            r_fall <= w_update & ~r_sync2;
        end
    end

    assign sw.o_sw_rise = r_rise;
    assign sw.o_sw_fall = r_fall;
`else
    assign sw.o_sw_rise = '0;
    assign sw.o_sw_fall = '0;
`endif

endmodule

`default_nettype wire
